// File: rtl/onehot_seq_checker.sv
// Receive-side checker for the 000->001->010->100 one-hot counter bus:
// decodes position, acquires lock, flags illegal codes and sequence slips.
module onehot_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       din,
  input  logic             din_valid,
  output logic [1:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic             code_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_prev, w_prev_nxt;
  logic [3:0]       r_good, w_good_nxt;
  logic [3:0]       r_miss, w_miss_nxt;
  logic             w_legal;
  logic [1:0]       w_dec;
  logic             w_match;
  logic [4:0]       w_good_inc, w_miss_inc;
  logic [1:0]       w_idx_nxt;
  logic             w_idx_valid_nxt, w_err_nxt, w_code_err_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b000:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 2'd0;
    case (din)
      3'b000:  w_dec = 2'd0;
      3'b001:  w_dec = 2'd1;
      3'b010:  w_dec = 2'd2;
      3'b100:  w_dec = 2'd3;
      default: w_legal = 1'b0;
    endcase
  end

  // r_prev is always a legal code, so an illegal din can never match
  assign w_match    = (din == next_code(r_prev));
  assign w_good_inc = {1'b0, r_good} + 5'd1;
  assign w_miss_inc = {1'b0, r_miss} + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HUNT;
      r_prev  <= 3'b000;
      r_good  <= 4'd0;
      r_miss  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_good  <= w_good_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    if (din_valid) begin
      case (r_state)
        S_HUNT: begin
          if (w_legal) begin
            w_prev_nxt  = din;
            w_good_nxt  = 4'd0;
            w_state_nxt = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (!w_legal) begin
            w_state_nxt = S_HUNT;
          end else if (w_match) begin
            w_prev_nxt = din;
            if (w_good_inc == 5'(LOCK_CNT)) begin
              w_good_nxt  = 4'd0;
              w_state_nxt = S_LOCKED;
            end else begin
              w_good_nxt = w_good_inc[3:0];
            end
          end else begin
            w_prev_nxt = din;
            w_good_nxt = 4'd0;
          end
        end
        S_LOCKED: begin
          if (w_match) begin
            w_prev_nxt = din;
            w_miss_nxt = 4'd0;
          end else begin
            // flywheel: keep predicting through the slip
            w_prev_nxt = next_code(r_prev);
            if (w_miss_inc == 5'(MISS_MAX)) begin
              w_miss_nxt  = 4'd0;
              w_state_nxt = S_HUNT;
            end else begin
              w_miss_nxt = w_miss_inc[3:0];
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_comb begin
    w_idx_nxt       = idx;
    w_idx_valid_nxt = 1'b0;
    w_code_err_nxt  = 1'b0;
    w_err_nxt       = 1'b0;
    w_cnt_nxt       = err_count;
    if (din_valid) begin
      if (w_legal) begin
        w_idx_nxt       = w_dec;
        w_idx_valid_nxt = 1'b1;
      end else begin
        w_code_err_nxt = 1'b1;
      end
      if (r_state == S_LOCKED && !w_match) begin
        w_err_nxt = 1'b1;
        w_cnt_nxt = sat_inc(err_count);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 2'd0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      code_err  <= 1'b0;
      err_count <= '0;
    end else begin
      idx       <= w_idx_nxt;
      idx_valid <= w_idx_valid_nxt;
      locked    <= (w_state_nxt == S_LOCKED);
      err       <= w_err_nxt;
      code_err  <= w_code_err_nxt;
      err_count <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_seq_checker.sv
// Bench for onehot_seq_checker: default instance plus a LOCK_CNT=1,
// MISS_MAX=1, CNT_W=2 instance, both checked against a position-based model.
module tb_onehot_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] din;
  logic       din_valid;

  logic [1:0] a_idx, b_idx;
  logic       a_iv, a_lk, a_err, a_ce;
  logic       b_iv, b_lk, b_err, b_ce;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_seq_checker #(.LOCK_CNT(3), .MISS_MAX(2), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .idx(a_idx), .idx_valid(a_iv), .locked(a_lk), .err(a_err),
    .code_err(a_ce), .err_count(a_cnt)
  );

  onehot_seq_checker #(.LOCK_CNT(1), .MISS_MAX(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .idx(b_idx), .idx_valid(b_iv), .locked(b_lk), .err(b_err),
    .code_err(b_ce), .err_count(b_cnt)
  );

  // Model works on sequence positions 0..3; successor is (p+1) mod 4.
  int m_mode[2];   // 0 hunt, 1 confirm, 2 locked
  int m_prev[2], m_good[2], m_miss[2], m_cnt[2], m_idx[2];
  bit m_iv[2], m_err[2], m_ce[2];
  int LC[2]   = '{3, 1};
  int MM[2]   = '{2, 1};
  int CMAX[2] = '{255, 3};

  function automatic int decode(input logic [2:0] d);
    case (d)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] enc(input int p);
    if (p == 0) return 3'b000;
    return 3'(1 << (p - 1));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_prev[k] = 0; m_good[k] = 0; m_miss[k] = 0;
      m_cnt[k] = 0; m_idx[k] = 0; m_iv[k] = 0; m_err[k] = 0; m_ce[k] = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] d, input logic v);
    int p;
    for (int k = 0; k < 2; k++) begin
      m_iv[k] = 0; m_err[k] = 0; m_ce[k] = 0;
      if (!v) continue;
      p = decode(d);
      if (p >= 0) begin m_iv[k] = 1; m_idx[k] = p; end
      else m_ce[k] = 1;
      case (m_mode[k])
        0: if (p >= 0) begin m_prev[k] = p; m_good[k] = 0; m_mode[k] = 1; end
        1: begin
          if (p < 0) m_mode[k] = 0;
          else if (p == (m_prev[k] + 1) % 4) begin
            m_prev[k] = p;
            m_good[k]++;
            if (m_good[k] == LC[k]) begin m_mode[k] = 2; m_good[k] = 0; end
          end else begin
            m_prev[k] = p; m_good[k] = 0;
          end
        end
        default: begin
          if (p >= 0 && p == (m_prev[k] + 1) % 4) begin
            m_prev[k] = p; m_miss[k] = 0;
          end else begin
            m_err[k] = 1;
            if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
            m_prev[k] = (m_prev[k] + 1) % 4;
            m_miss[k]++;
            if (m_miss[k] == MM[k]) begin m_mode[k] = 0; m_miss[k] = 0; end
          end
        end
      endcase
    end
  endtask

  function automatic logic [13:0] obs(input int k);
    if (k == 0) return {a_idx, a_iv, a_lk, a_err, a_ce, a_cnt};
    return {b_idx, b_iv, b_lk, b_err, b_ce, 6'd0, b_cnt};
  endfunction

  function automatic logic [13:0] expv(input int k);
    logic [7:0] c;
    logic [1:0] ix;
    c  = 8'(m_cnt[k]);
    ix = 2'(m_idx[k]);
    return {ix, m_iv[k], (m_mode[k] == 2), m_err[k], m_ce[k], c};
  endfunction

  // One sampling edge: drive on the falling edge, step the model on the
  // rising edge, return 1 time unit later for sampling.
  task automatic cycle(input logic [2:0] d, input logic v);
    @(negedge clk);
    din = d;
    din_valid = v;
    @(posedge clk);
    model_step(d, v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    din_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 3'b000; din_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 14'h0) begin
        errors++;
        $display("FAIL reset_init[%0d] got %h want 0", k, obs(k));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    // lock, then hit reset asynchronously between edges
    for (int i = 0; i < 5; i++) cycle(enc(i % 4), 1'b1);
    checks++;
    if (a_lk !== 1'b1) begin
      errors++;
      $display("FAIL reset_prelock got %b want 1", a_lk);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 14'h0) begin
        errors++;
        $display("FAIL reset_async[%0d] got %h want 0", k, obs(k));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs(0) !== 14'h0) begin
      errors++;
      $display("FAIL reset_hold got %h want 0", obs(0));
    end
    @(negedge clk);
    reset = 1'b0;
    cycle(3'b001, 1'b1);
    checks++;
    if ({a_idx, a_iv, a_lk, a_err} !== {2'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_resume got %b want 01100", {a_idx, a_iv, a_lk, a_err});
    end
  endtask

  task automatic test_lock();
    logic [1:0] want_idx [5];
    want_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(enc(i % 4), 1'b1);
      checks++;
      if ({a_idx, a_iv, a_lk, a_err} !== {want_idx[i], 1'b1, (i >= 3), 1'b0}) begin
        errors++;
        $display("FAIL lock_seq s%0d got idx=%0d iv=%b lk=%b err=%b want idx=%0d lk=%b",
                 i, a_idx, a_iv, a_lk, a_err, want_idx[i], (i >= 3));
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL lock_model[%0d] s%0d got %h want %h", k, i, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_skip();
    logic [2:0] seq [3];
    seq = '{3'b001, 3'b100, 3'b000};
    for (int i = 0; i < 3; i++) begin
      cycle(seq[i], 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL skip_model[%0d] s%0d got %h want %h", k, i, obs(k), expv(k));
        end
      end
      if (i == 1) begin
        checks++;
        if ({a_err, a_lk, a_cnt} !== {1'b1, 1'b1, 8'd1}) begin
          errors++;
          $display("FAIL skip_first got err=%b lk=%b cnt=%0d want 1 1 1", a_err, a_lk, a_cnt);
        end
      end
      if (i == 2) begin
        checks++;
        if ({a_err, a_lk, a_cnt} !== {1'b1, 1'b0, 8'd2}) begin
          errors++;
          $display("FAIL skip_drop got err=%b lk=%b cnt=%0d want 1 0 2", a_err, a_lk, a_cnt);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] seq [4];
    seq = '{3'b001, 3'b011, 3'b100, 3'b010};
    do_reset();
    for (int i = 0; i < 5; i++) cycle(enc(i % 4), 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(seq[i], 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL illegal_model[%0d] s%0d got %h want %h", k, i, obs(k), expv(k));
        end
      end
    end
    // last step: a single mismatch after the cleared miss keeps lock
    checks++;
    if ({a_err, a_lk, a_ce, a_cnt} !== {1'b1, 1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL illegal_missclr got err=%b lk=%b ce=%b cnt=%0d want 1 1 0 2",
               a_err, a_lk, a_ce, a_cnt);
    end
  endtask

  task automatic test_illegal_pulse();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(enc(i % 4), 1'b1);
    cycle(3'b111, 1'b1);
    checks++;
    if ({a_ce, a_err, a_iv, a_idx, a_lk} !== {1'b1, 1'b1, 1'b0, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL illegal_pulse got ce=%b err=%b iv=%b idx=%0d lk=%b want 1 1 0 1 1",
               a_ce, a_err, a_iv, a_idx, a_lk);
    end
  endtask

  task automatic test_saturation();
    logic [2:0] seq [3];
    seq = '{3'b000, 3'b001, 3'b100};
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) begin
        cycle(seq[i], 1'b1);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obs(k) !== expv(k)) begin
            errors++;
            $display("FAIL sat_model[%0d] r%0d s%0d got %h want %h", k, r, i, obs(k), expv(k));
          end
        end
      end
    end
    checks++;
    if (b_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold got %0d want 3", b_cnt);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(enc(i % 4), 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL gap_model[%0d] s%0d got %h want %h", k, i, obs(k), expv(k));
        end
      end
      cycle(3'($urandom), 1'b0);
      checks++;
      if ({a_iv, a_err, a_ce, b_iv, b_err, b_ce} !== 6'b0) begin
        errors++;
        $display("FAIL gap_idle s%0d got %b want 000000", i, {a_iv, a_err, a_ce, b_iv, b_err, b_ce});
      end
      checks++;
      if (a_lk !== (i >= 3)) begin
        errors++;
        $display("FAIL gap_lock s%0d got %b want %b", i, a_lk, (i >= 3));
      end
    end
  endtask

  task automatic test_random();
    int pos = 0;
    int r;
    logic [2:0] d;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom % 16);
      if (r < 12) begin
        pos = (pos + 1) % 4;
        d = enc(pos);
      end else if (r < 14) begin
        pos = int'($urandom % 4);
        d = enc(pos);
      end else begin
        d = 3'($urandom);
      end
      cycle(d, ($urandom % 4) != 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL rand_model[%0d] c%0d din=%b got %h want %h", k, i, d, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_skip();
    test_illegal();
    test_illegal_pulse();
    test_saturation();
    test_gapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
